l2_arbiter: RTL
===============

L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, L1-to-L2 block address width.
REQ-002 SHALL have parameter DATA_W, default 128, block data width.
REQ-003 SHALL have parameter CNT_W, default 16, width of the grant counters.
REQ-004 SHALL have clk, input, 1, the single clock; all state updates on posedge clk.
REQ-005 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ic_read, input, 1, I-cache miss read request.
REQ-007 SHALL have ic_addr, input, ADDR_W, I-cache block address.
REQ-008 SHALL have ic_rdata, output, DATA_W, block returned to the I-cache.
REQ-009 SHALL have ic_ready, output, 1, I-cache transaction complete.
REQ-010 SHALL have dc_read and dc_write, input, 1 each, D-cache read and write-back requests (mutually exclusive).
REQ-011 SHALL have dc_addr, input, ADDR_W, and dc_wdata, input, DATA_W.
REQ-012 SHALL have dc_rdata, output, DATA_W, and dc_ready, output, 1.
REQ-013 SHALL have l2_read and l2_write, output, 1 each, and l2_addr, output, ADDR_W.
REQ-014 SHALL have l2_wdata, output, DATA_W.
REQ-015 SHALL have l2_rdata, input, DATA_W, and l2_ready, input, 1.
REQ-016 SHALL have busy, output, 1, high in GNT_I or GNT_D.
REQ-017 SHALL have ic_gnt_cnt and dc_gnt_cnt, output, CNT_W each, completed-transaction counters.

Function
REQ-018 SHALL implement a registered FSM with states IDLE, GNT_I, GNT_D and DONE.
REQ-019 IDLE, requests from only one side SHALL move the FSM to that side's GNT state on the next edge.
REQ-020 IDLE, simultaneous requests SHALL grant the side not served last; last_gnt resets to I, so D wins the first contention.
REQ-021 GNT_I SHALL drive l2_read=ic_read, l2_write=0, l2_addr=ic_addr and l2_wdata=0.
REQ-022 GNT_D SHALL drive l2_read=dc_read, l2_write=dc_write, l2_addr=dc_addr and l2_wdata=dc_wdata.
REQ-023 In IDLE and DONE, all l2_* outputs SHALL be 0 and ic_ready=dc_ready=0.
REQ-024 In a GNT state, the granted *_ready SHALL equal l2_ready combinationally, with zero added latency.
REQ-025 The non-granted *_ready SHALL be 0.
REQ-026 ic_rdata and dc_rdata SHALL both equal l2_rdata at all times; a requester samples them only on its ready.
REQ-027 GNT state with l2_ready=1 SHALL move to DONE and update last_gnt.
REQ-028 GNT state with l2_ready=1 SHALL increment the served side's counter, saturating at all-ones.
REQ-029 GNT state with l2_ready=0 SHALL hold the grant; the grant is never revoked mid-transaction.
REQ-030 DONE SHALL last exactly one cycle, then return to IDLE, giving the requester one cycle to drop its request.
REQ-031 A GNT state whose request drops without l2_ready SHALL return to IDLE without counting.
REQ-032 A D-cache write-back followed by a refill read SHALL be two transactions; an I request pending in between SHALL be served between them.
REQ-033 Minimum request-to-grant latency SHALL be 1 cycle; back-to-back grants to alternating sides SHALL be 2 cycles apart (DONE plus IDLE).
REQ-034 Worst-case wait SHALL be one full transaction of the other side plus 2 cycles, so there is no starvation.

Reset
REQ-035 rst=1 SHALL asynchronously force IDLE and last_gnt=I.
REQ-036 rst=1 SHALL asynchronously zero both counters and busy.
REQ-037 rst=1 SHALL asynchronously force all l2_* outputs and both *_ready to 0, including mid-transaction.
REQ-038 After rst deasserts, the first arbitration SHALL occur on the first posedge.

Verification
REQ-039 I only: ic_read=1, ic_addr=28'h0000040, l2_ready after 3 cycles -> GNT_I; l2_read=1 and l2_addr=28'h0000040; ic_ready pulses 1 cycle; ic_gnt_cnt=1; dc_ready stays 0.
REQ-040 Contention after reset: both request -> D granted first; after D's ready, then DONE and IDLE, I granted; dc_gnt_cnt=1, ic_gnt_cnt=1.
REQ-041 D write-back: dc_write=1, dc_wdata=128'hA5..A5 -> l2_write=1 and l2_wdata matches.
REQ-042 D write-back then D read with ic_read held -> order D-write, I, D-read.
REQ-043 Reset mid-GNT_D: rst pulsed, l2_ready=0 -> l2_write and busy go to 0 without waiting for clk; counters 0; next grant follows REQ-020.
REQ-044 Saturation: CNT_W=4, 17 I transactions -> ic_gnt_cnt=4'hF.

Source files
------------

// File: rtl/l2_arbiter_if.sv
// L1-to-L2 bus bundle: I-cache and D-cache request ports, L2 port, status.
// The arbiter takes the slave view; the caches/L2 side takes the master view.
interface l2_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
);
  logic              ic_read;
  logic [ADDR_W-1:0] ic_addr;
  logic [DATA_W-1:0] ic_rdata;
  logic              ic_ready;
  logic              dc_read;
  logic              dc_write;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic [DATA_W-1:0] dc_rdata;
  logic              dc_ready;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [DATA_W-1:0] l2_wdata;
  logic [DATA_W-1:0] l2_rdata;
  logic              l2_ready;
  logic              busy;
  logic [CNT_W-1:0]  ic_gnt_cnt;
  logic [CNT_W-1:0]  dc_gnt_cnt;

  modport slave (
    input  ic_read, ic_addr, dc_read, dc_write, dc_addr, dc_wdata, l2_rdata, l2_ready,
    output ic_rdata, ic_ready, dc_rdata, dc_ready, l2_read, l2_write, l2_addr, l2_wdata,
           busy, ic_gnt_cnt, dc_gnt_cnt
  );

  modport master (
    output ic_read, ic_addr, dc_read, dc_write, dc_addr, dc_wdata, l2_rdata, l2_ready,
    input  ic_rdata, ic_ready, dc_rdata, dc_ready, l2_read, l2_write, l2_addr, l2_wdata,
           busy, ic_gnt_cnt, dc_gnt_cnt
  );
endinterface

// File: rtl/l2_arbiter.sv
// Two-requester L2 arbiter: I-cache vs D-cache, alternating priority on contention,
// grant held until l2_ready, one DONE cycle between transactions.
module l2_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst,
  l2_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_t;
  typedef enum logic {SIDE_I, SIDE_D} side_t;

  state_t            state_q, state_d;
  side_t             last_q, last_d;
  logic [CNT_W-1:0]  ic_cnt_q, ic_cnt_d;
  logic [CNT_W-1:0]  dc_cnt_q, dc_cnt_d;

  logic              ic_req, dc_req;
  logic              l2_read_c, l2_write_c, ic_ready_c, dc_ready_c;
  logic [ADDR_W-1:0] l2_addr_c;
  logic [DATA_W-1:0] l2_wdata_c;

  assign ic_req = bus.ic_read;
  assign dc_req = bus.dc_read | bus.dc_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= SIDE_I;
      ic_cnt_q <= '0;
      dc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      ic_cnt_q <= ic_cnt_d;
      dc_cnt_q <= dc_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    ic_cnt_d   = ic_cnt_q;
    dc_cnt_d   = dc_cnt_q;
    l2_read_c  = 1'b0;
    l2_write_c = 1'b0;
    l2_addr_c  = '0;
    l2_wdata_c = '0;
    ic_ready_c = 1'b0;
    dc_ready_c = 1'b0;
    case (state_q)
      IDLE: begin
        // On contention the side not served last wins
        if (ic_req && dc_req)
          state_d = (last_q == SIDE_I) ? GNT_D : GNT_I;
        else if (ic_req)
          state_d = GNT_I;
        else if (dc_req)
          state_d = GNT_D;
      end
      GNT_I: begin
        l2_read_c  = bus.ic_read;
        l2_addr_c  = bus.ic_addr;
        ic_ready_c = bus.l2_ready;
        if (bus.l2_ready) begin
          state_d = DONE;
          last_d  = SIDE_I;
          if (ic_cnt_q != '1) ic_cnt_d = ic_cnt_q + CNT_W'(1);
        end else if (!ic_req) begin
          state_d = IDLE;
        end
      end
      GNT_D: begin
        l2_read_c  = bus.dc_read;
        l2_write_c = bus.dc_write;
        l2_addr_c  = bus.dc_addr;
        l2_wdata_c = bus.dc_wdata;
        dc_ready_c = bus.l2_ready;
        if (bus.l2_ready) begin
          state_d = DONE;
          last_d  = SIDE_D;
          if (dc_cnt_q != '1) dc_cnt_d = dc_cnt_q + CNT_W'(1);
        end else if (!dc_req) begin
          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.l2_read    = l2_read_c;
  assign bus.l2_write   = l2_write_c;
  assign bus.l2_addr    = l2_addr_c;
  assign bus.l2_wdata   = l2_wdata_c;
  assign bus.ic_ready   = ic_ready_c;
  assign bus.dc_ready   = dc_ready_c;
  assign bus.ic_rdata   = bus.l2_rdata;
  assign bus.dc_rdata   = bus.l2_rdata;
  assign bus.busy       = (state_q == GNT_I) || (state_q == GNT_D);
  assign bus.ic_gnt_cnt = ic_cnt_q;
  assign bus.dc_gnt_cnt = dc_cnt_q;

endmodule
